// File: rtl/set24_time_editor.sv
// set24_time_editor: push-button editor for the 24-hour clock-set mode.
// Latency: a step lands on the edge that first samples the button; enter/next act on the sampling edge.
// Backpressure: none; enter/next are one-cycle pulses and up/down are debounced levels.
//
// Ports:
//   clk, reset          - system clock, asynchronous active-high reset
//   enter, next         - one-cycle pulses: start/finish an edit, advance field
//   up, down            - debounced levels: step the selected field, auto-repeat while held
//   load_hours/minutes  - current time, captured when an edit starts
//   hours, minutes      - registered edited value (always in legal range)
//   editing, field      - edit-in-progress flag and selected field (0 = hours, 1 = minutes)
//   commit              - one-cycle pulse when the edited value is final
module set24_time_editor #(
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       next,
  input  logic       up,
  input  logic       down,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic       editing,
  output logic       field,
  output logic       commit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EDIT_H = 2'd1;
  localparam logic [1:0] S_EDIT_M = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [4:0]       hours_q, hours_d;
  logic [5:0]       minutes_q, minutes_d;
  logic             up_prev_q, up_prev_d;
  logic             down_prev_q, down_prev_d;
  // cnt_q == 0 means "not armed": only a fresh rising edge can start stepping.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // rep_q selects the repeat period once the initial delay has elapsed.
  logic             rep_q, rep_d;

  logic up_only, down_only, do_step;

  always_comb begin
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    up_prev_d   = up;
    down_prev_d = down;
    do_step     = 1'b0;
    up_only     = up & ~down;
    down_only   = down & ~up;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        rep_d = 1'b0;
        if (enter) begin
          state_d   = S_EDIT_H;
          hours_d   = (load_hours > 5'd23) ? 5'd0 : load_hours;
          minutes_d = (load_minutes > 6'd59) ? 6'd0 : load_minutes;
        end
      end
      S_EDIT_H, S_EDIT_M: begin
        if (enter || next) begin
          // Field/state change drops any step in this cycle and disarms repeat.
          state_d = (enter || state_q == S_EDIT_M) ? S_COMMIT : S_EDIT_M;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end else if ((up_only && !up_prev_q) || (down_only && !down_prev_q)) begin
          do_step = 1'b1;
          cnt_d   = ONE_C;
          rep_d   = 1'b0;
        end else if (((up_only && up_prev_q) || (down_only && down_prev_q)) && cnt_q != '0) begin
          if (cnt_q == (rep_q ? PERIOD_C : DELAY_C)) begin
            do_step = 1'b1;
            cnt_d   = ONE_C;
            rep_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end else begin
          cnt_d = '0;
          rep_d = 1'b0;
        end

        if (do_step) begin
          if (state_q == S_EDIT_H) begin
            if (up_only) hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            else         hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
          end else begin
            if (up_only) minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
            else         minutes_d = (minutes_q == 6'd0) ? 6'd59 : minutes_q - 6'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        rep_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hours_q     <= 5'd0;
      minutes_q   <= 6'd0;
      up_prev_q   <= 1'b0;
      down_prev_q <= 1'b0;
      cnt_q       <= '0;
      rep_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      up_prev_q   <= up_prev_d;
      down_prev_q <= down_prev_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
    end
  end

  assign hours   = hours_q;
  assign minutes = minutes_q;
  assign editing = (state_q == S_EDIT_H) || (state_q == S_EDIT_M);
  assign field   = (state_q == S_EDIT_M);
  assign commit  = (state_q == S_COMMIT);

endmodule

// File: tb/tb_set24_time_editor.sv
module tb_set24_time_editor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0, next = 1'b0, up = 1'b0, down = 1'b0;
  logic [4:0] load_hours = 5'd0;
  logic [5:0] load_minutes = 6'd0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic       editing, field, commit;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [4:0] h;
    logic [5:0] m;
    logic       e;
    logic       f;
    logic       c;
  } exp_t;

  exp_t sb[$];

  set24_time_editor #(.REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut (
    .clk(clk), .reset(reset), .enter(enter), .next(next), .up(up), .down(down),
    .load_hours(load_hours), .load_minutes(load_minutes),
    .hours(hours), .minutes(minutes), .editing(editing), .field(field), .commit(commit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] h, input logic [5:0] m,
                            input logic e, input logic f, input logic c);
    exp_t x;
    x.tag = tag; x.h = h; x.m = m; x.e = e; x.f = f; x.c = c;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty got 0 entries required 1");
      return;
    end
    x = sb.pop_front();
    vectors++;
    assert (hours === x.h) else begin
      miscompares++;
      $error("FAIL %s hours got %0d required %0d", x.tag, hours, x.h);
    end
    assert (minutes === x.m) else begin
      miscompares++;
      $error("FAIL %s minutes got %0d required %0d", x.tag, minutes, x.m);
    end
    assert (editing === x.e) else begin
      miscompares++;
      $error("FAIL %s editing got %b required %b", x.tag, editing, x.e);
    end
    assert (field === x.f) else begin
      miscompares++;
      $error("FAIL %s field got %b required %b", x.tag, field, x.f);
    end
    assert (commit === x.c) else begin
      miscompares++;
      $error("FAIL %s commit got %b required %b", x.tag, commit, x.c);
    end
  endtask

  // Drive current inputs across one edge, then compare against the queued expectation.
  task automatic step_chk(input string tag, input logic [4:0] h, input logic [5:0] m,
                          input logic e, input logic f, input logic c);
    expect_out(tag, h, m, e, f, c);
    tick();
    check_out();
  endtask

  initial begin
    // Reset state
    #1;
    expect_out("reset", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    tick();
    reset = 1'b0;
    step_chk("idle_after_reset", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    // Capture with clamp of out-of-range hours
    load_hours = 5'd26; load_minutes = 6'd45; enter = 1'b1;
    step_chk("capture_clamp", 5'd0, 6'd45, 1'b1, 1'b0, 1'b0);
    enter = 1'b0;

    // next + up rising together: field change wins, step dropped and not deferred
    next = 1'b1; up = 1'b1;
    step_chk("prio_next_up", 5'd0, 6'd45, 1'b1, 1'b1, 1'b0);
    next = 1'b0;
    step_chk("prio_held_no_step", 5'd0, 6'd45, 1'b1, 1'b1, 1'b0);
    step_chk("prio_held_no_step2", 5'd0, 6'd45, 1'b1, 1'b1, 1'b0);
    up = 1'b0;
    step_chk("prio_release", 5'd0, 6'd45, 1'b1, 1'b1, 1'b0);
    enter = 1'b1;
    step_chk("enter_commit", 5'd0, 6'd45, 1'b0, 1'b0, 1'b1);
    enter = 1'b0;
    step_chk("back_idle", 5'd0, 6'd45, 1'b0, 1'b0, 1'b0);

    // Wrap tests
    load_hours = 5'd23; load_minutes = 6'd59; enter = 1'b1;
    step_chk("capture_23_59", 5'd23, 6'd59, 1'b1, 1'b0, 1'b0);
    enter = 1'b0; up = 1'b1;
    step_chk("hours_wrap_up", 5'd0, 6'd59, 1'b1, 1'b0, 1'b0);
    up = 1'b0;
    step_chk("hours_release", 5'd0, 6'd59, 1'b1, 1'b0, 1'b0);
    down = 1'b1;
    step_chk("hours_wrap_down", 5'd23, 6'd59, 1'b1, 1'b0, 1'b0);
    down = 1'b0;
    step_chk("hours_release2", 5'd23, 6'd59, 1'b1, 1'b0, 1'b0);
    next = 1'b1;
    step_chk("to_minutes", 5'd23, 6'd59, 1'b1, 1'b1, 1'b0);
    next = 1'b0; up = 1'b1;
    step_chk("min_wrap_up", 5'd23, 6'd0, 1'b1, 1'b1, 1'b0);
    up = 1'b0;
    step_chk("min_release", 5'd23, 6'd0, 1'b1, 1'b1, 1'b0);
    down = 1'b1;
    step_chk("min_wrap_down", 5'd23, 6'd59, 1'b1, 1'b1, 1'b0);
    down = 1'b0;
    step_chk("min_release2", 5'd23, 6'd59, 1'b1, 1'b1, 1'b0);
    enter = 1'b1;
    step_chk("enter_commit_m", 5'd23, 6'd59, 1'b0, 1'b0, 1'b1);
    enter = 1'b0;
    step_chk("idle2", 5'd23, 6'd59, 1'b0, 1'b0, 1'b0);

    // Auto-repeat: DELAY=4, PERIOD=2, steps at k, k+4, k+6, k+8, k+10
    load_hours = 5'd10; load_minutes = 6'd30; enter = 1'b1;
    step_chk("capture_10_30", 5'd10, 6'd30, 1'b1, 1'b0, 1'b0);
    enter = 1'b0; up = 1'b1;
    step_chk("rpt_k", 5'd11, 6'd30, 1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      int exp_h;
      exp_h = 11 + ((j >= 4) ? 1 : 0) + ((j >= 6) ? 1 : 0) + ((j >= 8) ? 1 : 0) + ((j >= 10) ? 1 : 0);
      step_chk($sformatf("rpt_k+%0d", j), 5'(exp_h), 6'd30, 1'b1, 1'b0, 1'b0);
    end
    up = 1'b0;
    step_chk("rpt_release", 5'd15, 6'd30, 1'b1, 1'b0, 1'b0);
    up = 1'b1; down = 1'b1;
    step_chk("both_high", 5'd15, 6'd30, 1'b1, 1'b0, 1'b0);
    step_chk("both_high2", 5'd15, 6'd30, 1'b1, 1'b0, 1'b0);
    up = 1'b0; down = 1'b0;
    step_chk("both_release", 5'd15, 6'd30, 1'b1, 1'b0, 1'b0);

    // Commit via next from minutes field
    next = 1'b1;
    step_chk("commit_to_m", 5'd15, 6'd30, 1'b1, 1'b1, 1'b0);
    step_chk("commit_pulse", 5'd15, 6'd30, 1'b0, 1'b0, 1'b1);
    next = 1'b0;
    step_chk("commit_done", 5'd15, 6'd30, 1'b0, 1'b0, 1'b0);
    up = 1'b1;
    step_chk("idle_up_ignored", 5'd15, 6'd30, 1'b0, 1'b0, 1'b0);
    step_chk("idle_up_ignored2", 5'd15, 6'd30, 1'b0, 1'b0, 1'b0);
    up = 1'b0;
    step_chk("idle3", 5'd15, 6'd30, 1'b0, 1'b0, 1'b0);

    // enter together with next in EDIT_H goes straight to COMMIT
    enter = 1'b1;
    step_chk("recapture", 5'd10, 6'd30, 1'b1, 1'b0, 1'b0);
    next = 1'b1;
    step_chk("enter_next_commit", 5'd10, 6'd30, 1'b0, 1'b0, 1'b1);
    enter = 1'b0; next = 1'b0;
    step_chk("idle4", 5'd10, 6'd30, 1'b0, 1'b0, 1'b0);

    // Reset mid-edit in EDIT_M with hours=7
    load_hours = 5'd7; load_minutes = 6'd20; enter = 1'b1;
    step_chk("capture_7_20", 5'd7, 6'd20, 1'b1, 1'b0, 1'b0);
    enter = 1'b0; next = 1'b1;
    step_chk("edit_m_7", 5'd7, 6'd20, 1'b1, 1'b1, 1'b0);
    next = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    expect_out("reset_async", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_out();
    step_chk("reset_held", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step_chk("reset_no_commit", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    step_chk("reset_no_commit2", 5'd0, 6'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/set24_time_editor.md
# set24_time_editor

Interactive time-setting controller for the 24-hour clock-set mode. From debounced push-button levels, it produces the registered `hours`/`minutes` pair that feeds the 24-hour set-display decoder. It supports field selection (hours, then minutes), up/down stepping with wrap-around, and hold-to-auto-repeat. On completion it issues a one-cycle `commit` pulse so the timekeeping core can load the edited value.

## Interface
- `REPEAT_DELAY`, default 500: cycles a step button must stay held, counted from its first step, before auto-repeat begins (≥2).
- `REPEAT_PERIOD`, default 100: cycles between auto-repeat steps (≥1).
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `enter`  input  1  single-cycle pulse; starts an edit when idle, finishes an edit when editing.
- `next`  input  1  single-cycle pulse; advances to the next field.
- `up`  input  1  debounced level; increments the current field.
- `down`  input  1  debounced level; decrements the current field.
- `load_hours`  input  5  current time, hours, captured on edit start.
- `load_minutes`  input  6  current time, minutes, captured on edit start.
- `hours`  output  5  edited hours, 0..23, registered.
- `minutes`  output  6  edited minutes, 0..59, registered.
- `editing`  output  1  high in EDIT_H and EDIT_M.
- `field`  output  1  0 = hours selected, 1 = minutes selected.
- `commit`  output  1  one-cycle pulse when the edited value is final.

## Operation
- **States**
  - IDLE: `hours`/`minutes` hold their values.
  - EDIT_H: up/down step `hours`.
  - EDIT_M: up/down step `minutes`.
  - COMMIT: one cycle only.
- **Transitions**
  - IDLE + `enter` → EDIT_H. Capture `load_hours` (replaced by 0 if >23) and `load_minutes` (replaced by 0 if >59).
  - EDIT_H + `next` → EDIT_M.
  - EDIT_M + `next` → COMMIT.
  - EDIT_H or EDIT_M + `enter` → COMMIT.
  - COMMIT → IDLE unconditionally.
- **Stepping** (EDIT states only)
  - Hours: +1 wraps 23→0; −1 wraps 0→23.
  - Minutes: +1 wraps 59→0; −1 wraps 0→59.
  - Arithmetic is at field width; the value never leaves its legal range.
- **Step qualification**
  - The block keeps registered previous samples of `up` and `down`.
  - Rising edge of exactly one button → immediate single step.
  - Continued hold: a repeat counter counts the cycles since that step. At `REPEAT_DELAY` it steps and reloads; thereafter it steps every `REPEAT_PERIOD`.
  - Release, both buttons high, a state change, or a field change → counter cleared and no step.
  - A new rising edge restarts the sequence.
- **Priority within one cycle:** `reset` > `enter` > `next` > up/down.
  - A step request in the same cycle as `enter` or `next` is dropped.
  - The dropped step is not deferred.
- **Inputs ignored in IDLE and COMMIT:** `next`, `up`, `down` (repeat counter held at 0).
- **`field`:** 0 in IDLE, EDIT_H, COMMIT; 1 in EDIT_M.

## Timing
- **Reset values** (asynchronous, immediate on `reset`): state IDLE, `hours`=0, `minutes`=0, `editing`=0, `field`=0, `commit`=0, repeat counter 0, previous-button samples 0.
- **Reset mid-edit:** aborts without `commit`; the edited value is lost.
- **`enter` sampled at edge k (IDLE):** captured values on `hours`/`minutes` and `editing`=1 after edge k.
- **`up` first sampled high at edge k:** new `hours` after edge k (zero-cycle latency relative to sampling).
- **Held `up`:** further steps at edges k+`REPEAT_DELAY`, k+`REPEAT_DELAY`+`REPEAT_PERIOD`, and so on.
- **`next` sampled at edge k in EDIT_M:**
  - COMMIT after edge k: `commit`=1, `editing`=0.
  - `hours`/`minutes` hold the final value during and after `commit`.
  - IDLE after edge k+1.
- **`commit` width:** exactly one cycle; never asserted outside COMMIT.

## Test plan
1. Reset mid-edit: `reset` pulse while in EDIT_M with `hours`=7 → immediately `hours`=0, `minutes`=0, `editing`=0, no `commit`.
2. Capture with clamp: IDLE, `load_hours`=26, `load_minutes`=45, `enter` → `hours`=0, `minutes`=45, `editing`=1, `field`=0.
3. Wrap: hours 23, one `up` tap → 0; `down` tap → 23. `next`, then minutes 59, `up` tap → 0; `down` tap → 59.
4. Auto-repeat with `REPEAT_DELAY`=4, `REPEAT_PERIOD`=2: hours 10, hold `up` 11 cycles from edge k → steps at k, k+4, k+6, k+8, k+10; `hours`=15. Both buttons high → no change.
5. Commit: EDIT_M, `minutes`=30, `next` → `commit` high exactly one cycle with `hours`/`minutes` stable, then IDLE. `up` in IDLE → no change.
6. Priority: EDIT_H, `next` and `up` rising in the same cycle → EDIT_M, `hours` unchanged. `enter` with `next` in EDIT_H → COMMIT.
